muldiv_iter: RTL and testbench
==============================

// Module: muldiv_iter
// PURPOSE
//  Iterative multiply/divide unit that implements the RV32M ops (MUL*, DIV*, REM*) beside the single-cycle ALU.
//  Operands arrive from the execute stage over a valid/ready handshake; the 1-bit-per-cycle datapath keeps area small.
//  Results return over a second valid/ready handshake to writeback. A flush input kills an op in flight (trap/mispredict).
// PARAMETERS
//  DATA_WIDTH  32  operand/result width in bits; must be even and >= 8
//  CNT_W       $clog2(DATA_WIDTH)+1  iteration counter width (derived, do not override)
// PORTS
//  clk        in   1           clock, all state updates on rising edge
//  rst        in   1           synchronous, active-high reset
//  flush      in   1           abort current op, return to IDLE next cycle
//  in_valid   in   1           request valid
//  in_ready   out  1           unit can accept a request (IDLE only)
//  op         in   3           funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  a          in   DATA_WIDTH  rs1 operand
//  b          in   DATA_WIDTH  rs2 operand
//  out_valid  out  1           result valid
//  out_ready  in   1           consumer accepts result
//  result     out  DATA_WIDTH  result, stable while out_valid && !out_ready
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1 (combinational from state), out_valid=0, result=0, counter=0.
//  FSM IDLE -> CALC on in_valid&&in_ready (operands, op and signs captured that edge).
//   IDLE -> DONE directly for div special cases (below): latency 1 cycle.
//   CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter counts DATA_WIDTH steps.
//   CALC -> DONE when counter reaches DATA_WIDTH-1 step done: out_valid asserts DATA_WIDTH+1 cycles after accept.
//   DONE: out_valid=1; -> IDLE on out_ready. in_ready=0 in CALC and DONE (no request overlap).
//  Signed handling: operands converted to magnitudes, unsigned core, sign applied to final value.
//   MULH: both signed; MULHSU: a signed, b unsigned; MULHU: both unsigned; MUL: low half (sign-independent).
//   DIV/REM: quotient sign = sa^sb; remainder sign = sign of dividend.
//  Product is 2*DATA_WIDTH bits; MUL returns [DATA_WIDTH-1:0], MULH* return [2*DATA_WIDTH-1:DATA_WIDTH].
//  Special cases (RISC-V defined, no exception):
//   divide by zero: DIV/DIVU -> all ones; REM/REMU -> a.
//   signed overflow a=most-negative, b=-1: DIV -> a; REM -> 0.
//  Multiply by zero is NOT shortcut; latency is fixed DATA_WIDTH+1 for all mul ops.
//  flush: highest priority after rst; in any state, next state IDLE, out_valid=0, result not delivered;
//   flush in same cycle as in_valid: request is NOT accepted. flush in DONE with out_ready: no handshake.
//  rst has priority over flush and all handshakes; reset mid-CALC discards the op.
//  result register only updates on entering DONE; holds value in IDLE afterwards (don't-care, not cleared).
// TESTING
//  MUL a=7,b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept.
//  MULH a=0x80000000,b=0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; all with 1-cycle latency.
//  Hold out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0; then release -> IDLE, in_ready=1.
//  Flush at CALC cycle 10 -> no out_valid ever for that op; next request accepted the following cycle, correct result.

Source files
------------

// File: rtl/muldiv_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_iter : iterative RV32M multiply/divide, one bit per cycle         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module muldiv_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     mb_q, mb_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     result_q, result_d;

  // Operand decode for the incoming request
  logic         a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf, neg_in;
  logic [W-1:0] a_mag, b_mag, special_res;

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa       = a_signed & a[W-1];
    sb       = b_signed & b[W-1];
    a_mag    = sa ? (-a) : a;
    b_mag    = sb ? (-b) : b;
    is_div   = op[2];
    div_zero = is_div && (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
    case (op)
      OP_MULH, OP_DIV:   neg_in = sa ^ sb;
      OP_MULHSU, OP_REM: neg_in = sa;
      default:           neg_in = 1'b0;
    endcase
    // op[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = op[1] ? a : '1;
    else          special_res = op[1] ? '0 : a;
  end

  // Datapath step: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [W:0]     mul_sum, div_diff;
  logic [2*W-1:0] mul_next, div_next, step_next, prod_s;
  logic [W-1:0]   div_sel, div_fin, fin_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_diff  = acc_q[2*W-1:W-1] - {1'b0, mb_q};
    div_next  = div_diff[W] ? {acc_q[2*W-2:0], 1'b0}
                            : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    step_next = op_q[2] ? div_next : mul_next;
    prod_s    = neg_q ? (-step_next) : step_next;
    div_sel   = op_q[1] ? step_next[2*W-1:W] : step_next[W-1:0];
    div_fin   = neg_q ? (-div_sel) : div_sel;
    if (op_q[2])              fin_res = div_fin;
    else if (op_q == OP_MUL)  fin_res = prod_s[W-1:0];
    else                      fin_res = prod_s[2*W-1:W];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mb_d        = mb_q;
    op_d        = op_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d  = op;
            neg_d = neg_in;
            if (div_zero || div_ovf) begin
              state_d     = S_DONE;
              result_d    = special_res;
              out_valid_d = 1'b1;
            end else begin
              state_d = S_CALC;
              cnt_d   = '0;
              acc_d   = {{W{1'b0}}, (is_div ? a_mag : b_mag)};
              mb_d    = is_div ? b_mag : a_mag;
            end
          end
        end
        S_CALC: begin
          acc_d = step_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) begin
            state_d     = S_DONE;
            result_d    = fin_res;
            out_valid_d = 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mb_q        <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mb_q        <= mb_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_iter : directed + random scoreboard bench for muldiv_iter      |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_muldiv_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    string        tag;
  } exp_t;
  exp_t sb_q[$];

  muldiv_iter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y);
    logic signed [63:0] xs, ys, xu, yu, p;
    logic signed [31:0] sx, sy, r;
    logic               ovf;
    xs  = {{32{x[31]}}, x};
    ys  = {{32{y[31]}}, y};
    xu  = {32'b0, x};
    yu  = {32'b0, y};
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0:    begin p = xu * yu; return p[31:0];  end
      3'd1:    begin p = xs * ys; return p[63:32]; end
      3'd2:    begin p = xs * yu; return p[63:32]; end
      3'd3:    begin p = xu * yu; return p[63:32]; end
      3'd4:    begin if (y == 0) return '1; if (ovf) return x; r = sx / sy; return r; end
      3'd5:    begin if (y == 0) return '1; return x / y; end
      3'd6:    begin if (y == 0) return x; if (ovf) return '0; r = sx % sy; return r; end
      default: begin if (y == 0) return x; return x % y; end
    endcase
  endfunction

  function automatic int lat_of(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y);
    if (o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      return 1;
    return W + 1;
  endfunction

  // Drive one request (entered #1 after an edge, DUT idle); leaves #1 after the accept edge
  task automatic issue(string tag, logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y,
                       logic [W-1:0] exp_res);
    exp_t e;
    e.res = exp_res;
    e.lat = lat_of(o, x, y);
    e.tag = tag;
    sb_q.push_back(e);
    op = o; a = x; b = y; in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, "_lat"}, n + 1, e.lat);
    check({e.tag, "_res"}, result, e.res);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({e.tag, "_hold_valid"}, out_valid, 1);
      check({e.tag, "_hold_res"}, result, e.res);
      check({e.tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({e.tag, "_release_valid"}, out_valid, 0);
    check({e.tag, "_release_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);           collect(5);
    issue("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); collect(0);
    issue("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); collect(0);
    issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); collect(0);
    issue("mul0", 3'd0, 32'd0, 32'h1234_5678, 32'd0);                 collect(0);
    issue("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);          collect(0);
    issue("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);          collect(0);
    issue("divu", 3'd5, 32'd100, 32'd7, 32'd14);                      collect(0);
    issue("remu", 3'd7, 32'd100, 32'd7, 32'd2);                       collect(0);
    issue("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);              collect(0);
    issue("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5);                      collect(0);
    issue("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);             collect(0);
    issue("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5);                     collect(0);
    issue("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); collect(2);
    issue("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);      collect(0);

    // Flush at the tenth CALC cycle, then an immediate new request
    op = 3'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    check("flush_calc_busy", in_ready, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    issue("after_flush", 3'd5, 32'd1000, 32'd33, 32'd30);            collect(0);

    // Flush together with a request in IDLE: not accepted
    op = 3'd4; a = 32'd5; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_req_in_ready", in_ready, 1);
    check("flush_req_out_valid", out_valid, 0);

    // Reset in the middle of CALC discards the op
    op = 3'd1; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (i == 3) ry = 32'd3;
      issue($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry, model(ro, rx, ry));
      collect(0);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
